// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_pkg
//  Description : Shared definitions for the Hack CPU control stage: FSM state
//                encoding, instruction field bit positions, default address
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int ADDR_W_DEF = 15;

    // Instruction word fields
    localparam int C_BIT   = 15;   // 1 = C-instruction, 0 = A-instruction
    localparam int A_BIT   = 12;   // ALU y operand: 1 = M, 0 = A
    localparam int CTL_HI  = 11;   // {zx,nx,zy,ny,f,no}
    localparam int CTL_LO  = 6;
    localparam int D1_BIT  = 5;    // dest A
    localparam int D2_BIT  = 4;    // dest D
    localparam int D3_BIT  = 3;    // dest M
    localparam int JUMP_HI = 2;    // {j1(ng), j2(zr), j3(pos)}
    localparam int JUMP_LO = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_STORE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hack_cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hack_cpu_ctrl_if
//  Description : Bus bundle between the Hack control stage and its
//                environment (instruction ROM, data RAM, external ALU).
//                master = control stage, slave = ROM/RAM/ALU side.
//  Ports       : fetch   instr_req, pc, instr, instr_valid
//                data    mem_addr, mem_re, mem_we, mem_wdata, mem_rdata,
//                        mem_ready
//                alu     alu_x, alu_y, alu_ctl, alu_out, alu_zr, alu_ng
//  Revision    : 1.0 - initial release
// ============================================================================
interface hack_cpu_ctrl_if #(
    parameter int ADDR_W = hack_pkg::ADDR_W_DEF
);
    logic              instr_req;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr;
    logic              instr_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    logic [15:0]       alu_x;
    logic [15:0]       alu_y;
    logic [5:0]        alu_ctl;
    logic [15:0]       alu_out;
    logic              alu_zr;
    logic              alu_ng;

    modport master (
        output instr_req, pc,
        input  instr, instr_valid,
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata, mem_ready,
        output alu_x, alu_y, alu_ctl,
        input  alu_out, alu_zr, alu_ng
    );

    modport slave (
        input  instr_req, pc,
        output instr, instr_valid,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata, mem_ready,
        input  alu_x, alu_y, alu_ctl,
        output alu_out, alu_zr, alu_ng
    );

endinterface
`default_nettype wire

// File: rtl/hack_jump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hack_jump_unit
//  Description : Combinational jump decision for a Hack C-instruction.
//  Ports       : jump  in  3  {j1,j2,j3} = ir[2:0]
//                zr    in  1  ALU result is zero
//                ng    in  1  ALU result is negative
//                take  out 1  jump condition satisfied
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_jump_unit (
    input  wire [2:0] jump,
    input  wire       zr,
    input  wire       ng,
    output logic      take
);

    // j1 = less than zero, j2 = equal to zero, j3 = greater than zero
    assign take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule
`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hack_cpu_ctrl
//  Description : Control/register stage for the 16-bit Hack CPU. Fetches
//                instructions, holds A, D and PC, drives the external ALU and
//                commits writebacks, jumps and data-memory accesses through a
//                four-state FETCH/LOAD/EXEC/STORE machine.
//  Ports       : clk    in   clock, rising edge
//                reset  in   synchronous active-high reset
//                bus    mst  fetch, data-memory and ALU signals
//                reg_a  out  architectural A register (debug)
//                reg_d  out  architectural D register (debug)
//  Note        : the ADDR_W given to the bus interface must match ADDR_W here.
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire                  clk,
    input  wire                  reset,
    hack_cpu_ctrl_if.master      bus,
    output logic [15:0]          reg_a,
    output logic [15:0]          reg_d
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       a;
    logic [15:0]       d;
    logic [15:0]       ir;
    logic [15:0]       m_latch;
    logic [ADDR_W-1:0] store_addr;
    logic [15:0]       wdata;
    logic              take;

    hack_jump_unit u_jump (
        .jump (ir[JUMP_HI:JUMP_LO]),
        .zr   (bus.alu_zr),
        .ng   (bus.alu_ng),
        .take (take)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                // Decide on the word being captured, not on the stale ir
                if (bus.instr_valid) begin
                    if (bus.instr[C_BIT] && bus.instr[A_BIT])
                        state_nxt = ST_LOAD;
                    else
                        state_nxt = ST_EXEC;
                end
            end
            ST_LOAD: begin
                if (bus.mem_ready)
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (ir[C_BIT] && ir[D3_BIT])
                    state_nxt = ST_STORE;
                else
                    state_nxt = ST_FETCH;
            end
            ST_STORE: begin
                if (bus.mem_ready)
                    state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            a          <= '0;
            d          <= '0;
            ir         <= '0;
            m_latch    <= '0;
            store_addr <= '0;
            wdata      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_FETCH: begin
                    if (bus.instr_valid)
                        ir <= bus.instr;
                end
                ST_LOAD: begin
                    if (bus.mem_ready)
                        m_latch <= bus.mem_rdata;
                end
                ST_EXEC: begin
                    if (!ir[C_BIT]) begin
                        a  <= {1'b0, ir[14:0]};
                        pc <= pc + PC_STEP;
                    end else begin
                        if (ir[D2_BIT])
                            d <= bus.alu_out;
                        if (ir[D1_BIT])
                            a <= bus.alu_out;
                        // Store address and jump target both use A as it was
                        // before this instruction's own A write
                        if (ir[D3_BIT]) begin
                            wdata      <= bus.alu_out;
                            store_addr <= a[ADDR_W-1:0];
                        end
                        pc <= take ? a[ADDR_W-1:0] : pc + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. instr_req is held low while reset is asserted so no fetch is
    // advertised until the machine is actually running.
    assign bus.instr_req = (state == ST_FETCH) && !reset;
    assign bus.pc        = pc;
    assign bus.mem_re    = (state == ST_LOAD);
    assign bus.mem_we    = (state == ST_STORE);
    assign bus.mem_addr  = (state == ST_STORE) ? store_addr : a[ADDR_W-1:0];
    assign bus.mem_wdata = wdata;
    assign bus.alu_x     = d;
    assign bus.alu_y     = ir[A_BIT] ? m_latch : a;
    assign bus.alu_ctl   = ir[CTL_HI:CTL_LO];

    assign reg_a = a;
    assign reg_d = d;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hack_cpu_ctrl
//  Description : Self-checking bench for hack_cpu_ctrl. Provides ROM, RAM and
//                Hack ALU models; expected memory transactions go into
//                scoreboard queues that a monitor drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_ctrl;

    localparam int AW = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] reg_a;
    logic [15:0] reg_d;

    int checks = 0;
    int failures = 0;

    logic [15:0] rom [0:32767];
    logic [15:0] ram [0:32767];
    int          rom_wait = 0;
    int          ram_wait = 0;

    logic [31:0] wq[$];   // {1'b0, addr, data}
    logic [14:0] rq[$];

    hack_cpu_ctrl_if #(.ADDR_W(AW)) bus ();

    hack_cpu_ctrl #(.ADDR_W(AW), .RESET_PC(15'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .reg_a (reg_a),
        .reg_d (reg_d)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Reference Hack ALU
    function automatic logic [15:0] hack_alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                             input logic [5:0] c);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] o;
        x = c[5] ? 16'h0 : x_in;
        x = c[4] ? ~x : x;
        y = c[3] ? 16'h0 : y_in;
        y = c[2] ? ~y : y;
        o = c[1] ? (x + y) : (x & y);
        return c[0] ? ~o : o;
    endfunction

    always_comb begin
        bus.alu_out = hack_alu(bus.alu_x, bus.alu_y, bus.alu_ctl);
        bus.alu_zr  = (bus.alu_out == 16'h0);
        bus.alu_ng  = bus.alu_out[15];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ROM/RAM responders: decide handshakes on the falling edge
    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.instr_req) begin
                if (rom_wait > 0) begin
                    bus.instr_valid = 1'b0;
                    rom_wait--;
                end else begin
                    bus.instr_valid = 1'b1;
                    bus.instr       = rom[bus.pc];
                end
            end else begin
                bus.instr_valid = 1'b0;
            end
            if (bus.mem_re || bus.mem_we) begin
                if (ram_wait > 0) begin
                    bus.mem_ready = 1'b0;
                    ram_wait--;
                end else begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = ram[bus.mem_addr];
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    end

    // Monitor: a transaction completes on the next rising edge when strobe and
    // ready are both high and reset is low; values are stable here.
    initial begin
        logic [31:0] ew;
        logic [14:0] er;
        forever begin
            @(negedge clk);
            #4;
            check("strobe_exclusive",
                  {31'b0, (bus.mem_re & bus.mem_we) | (bus.instr_req & (bus.mem_re | bus.mem_we))}, 32'd0);
            if (!reset && bus.mem_ready && bus.mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {1'b0, bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    ew = wq.pop_front();
                    check("mem_write", {1'b0, bus.mem_addr, bus.mem_wdata}, ew);
                end
                ram[bus.mem_addr] = bus.mem_wdata;
            end
            if (!reset && bus.mem_ready && bus.mem_re) begin
                if (rq.size() == 0) begin
                    check("unexpected_read", {17'b0, bus.mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    er = rq.pop_front();
                    check("mem_read_addr", {17'b0, bus.mem_addr}, {17'b0, er});
                end
            end
        end
    end

    // Wait (bounded) until the DUT requests a fetch at the given pc
    task automatic wait_fetch(input logic [14:0] target, input int budget, input string name,
                              output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge clk);
            #3;
            cycles++;
            hit = bus.instr_req && (bus.pc == target);
        end
        check(name, {31'b0, hit}, 32'd1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
        // 1: D=2+3, M[0]=D
        rom[0]  = 16'h0002; rom[1]  = 16'hEC10; rom[2]  = 16'h0003;
        rom[3]  = 16'hE090; rom[4]  = 16'h0000; rom[5]  = 16'hE308;
        // 2: D=1, A=7, D=D+M with M[7]=9
        rom[6]  = 16'h0001; rom[7]  = 16'hEC10; rom[8]  = 16'h0007; rom[9]  = 16'hF090;
        // 3: jumps
        rom[10] = 16'h0000; rom[11] = 16'hEC10; rom[12] = 16'h0014; rom[13] = 16'hE302;
        rom[20] = 16'h0001; rom[21] = 16'hEC10; rom[22] = 16'h0064; rom[23] = 16'hE302;
        rom[24] = 16'hEE90; rom[25] = 16'h001E; rom[26] = 16'hE304;
        // 4: A=20; 0xFDE8 has a=1 so it is AM=M+1; M[20]=20 gives 21
        rom[30] = 16'h0014; rom[31] = 16'hFDE8;
        // 5: A=5, M=D with D=-1, memory stalls
        rom[32] = 16'h0005; rom[33] = 16'hE308;
        ram[7]  = 16'd9;
        ram[20] = 16'd20;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        check("rst_instr_req", {31'b0, bus.instr_req}, 32'd0);
        check("rst_mem_re",    {31'b0, bus.mem_re}, 32'd0);
        check("rst_mem_we",    {31'b0, bus.mem_we}, 32'd0);
        check("rst_pc",        {17'b0, bus.pc}, 32'd0);
        check("rst_reg_a",     {16'b0, reg_a}, 32'd0);
        check("rst_reg_d",     {16'b0, reg_d}, 32'd0);

        // Test 1
        wq.push_back({1'b0, 15'd0, 16'd5});
        reset = 1'b0;
        wait_fetch(15'd0, 4, "t1_fetch0", cyc);
        wait_fetch(15'd1, 4, "t1_fetch1", cyc);
        check("t1_a_latency", cyc, 32'd2);
        wait_fetch(15'd6, 30, "t1_reach_pc6", cyc);
        check("t1_reg_d", {16'b0, reg_d}, 32'd5);
        check("t1_ram0", {16'b0, ram[0]}, 32'd5);

        // Test 2
        rq.push_back(15'd7);
        wait_fetch(15'd9, 20, "t2_fetch9", cyc);
        wait_fetch(15'd10, 6, "t2_fetch10", cyc);
        check("t2_dm_latency", cyc, 32'd3);
        check("t2_reg_d", {16'b0, reg_d}, 32'd10);
        check("t2_no_write_left", wq.size(), 32'd0);

        // Test 3
        wait_fetch(15'd13, 20, "t3_fetch13", cyc);
        wait_fetch(15'd20, 3, "t3_jeq_taken", cyc);
        wait_fetch(15'd23, 20, "t3_fetch23", cyc);
        wait_fetch(15'd24, 3, "t3_jeq_not_taken", cyc);
        check("t3_reg_a_after_jeq", {16'b0, reg_a}, 32'd100);
        wait_fetch(15'd26, 10, "t3_fetch26", cyc);
        wait_fetch(15'd30, 3, "t3_jlt_taken", cyc);

        // Test 4
        rq.push_back(15'd20);
        wq.push_back({1'b0, 15'd20, 16'd21});
        wait_fetch(15'd31, 6, "t4_fetch31", cyc);
        wait_fetch(15'd32, 8, "t4_fetch32", cyc);
        check("t4_rw_latency", cyc, 32'd4);
        check("t4_reg_a", {16'b0, reg_a}, 32'd21);
        check("t4_reg_d", {16'b0, reg_d}, 32'hFFFF);

        // Test 5: stalled store, then reset mid-wait
        wait_fetch(15'd33, 6, "t5_fetch33", cyc);
        ram_wait = 100;
        begin
            int n = 0;
            while (!bus.mem_we && n < 4) begin
                @(negedge clk);
                #3;
                n++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #3;
            end
            check("t5_we_held",    {31'b0, bus.mem_we}, 32'd1);
            check("t5_addr_held",  {17'b0, bus.mem_addr}, 32'd5);
            check("t5_wdata_held", {16'b0, bus.mem_wdata}, 32'hFFFF);
        end
        reset = 1'b1;
        @(negedge clk);
        #3;
        ram_wait = 0;
        check("t5_rst_we",   {31'b0, bus.mem_we}, 32'd0);
        check("t5_rst_pc",   {17'b0, bus.pc}, 32'd0);
        check("t5_rst_a",    {16'b0, reg_a}, 32'd0);
        check("t5_rst_d",    {16'b0, reg_d}, 32'd0);
        check("t5_no_write", {16'b0, ram[5]}, 32'd0);

        // Test 6: PC wrap and fetch stall
        rom[0]      = 16'h7FFF;
        rom[1]      = 16'hEA87;   // 0;JMP
        rom[15'h7FFF] = 16'h0003;
        reset = 1'b0;
        wait_fetch(15'd0, 4, "t6_fetch0", cyc);
        wait_fetch(15'd1, 4, "t6_fetch1", cyc);
        rom_wait = 3;
        wait_fetch(15'h7FFF, 6, "t6_fetch_top", cyc);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #3;
            end
            check("t6_req_held", {31'b0, bus.instr_req}, 32'd1);
            check("t6_pc_held",  {17'b0, bus.pc}, 32'h7FFF);
            check("t6_a_held",   {16'b0, reg_a}, 32'h7FFF);
        end
        wait_fetch(15'd0, 4, "t6_pc_wrap", cyc);
        check("t6_wrap_latency", cyc, 32'd3);
        check("t6_reg_a", {16'b0, reg_a}, 32'd3);

        check("end_wq_empty", wq.size(), 32'd0);
        check("end_rq_empty", rq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
